// File: rtl/sme_feeder.sv
// sme_feeder: buffers string/pattern records in a 32-entry FIFO and replays whole records to the SME.
// Build macro SME_FEEDER_TIMEOUT_EN adds a 4095-cycle no-result timeout while waiting in WAIT.
module sme_feeder (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_type,
    input  logic       in_last,
    output logic [7:0] chardata,
    output logic       isstring,
    output logic       ispattern,
    input  logic       sme_valid,
    input  logic       sme_match,
    input  logic [4:0] sme_index,
    output logic       res_valid,
    output logic       res_match,
    output logic [4:0] res_index,
    output logic       trunc_err,
    output logic       busy
);

    localparam int DEPTH = 32;

    typedef enum logic [1:0] {IDLE, STR, PAT, WAIT} state_t;

    typedef struct packed {
        logic       typ;
        logic       last;
        logic [7:0] data;
    } entry_t;

    entry_t     mem [DEPTH];
    logic [4:0] wr_ptr_q, rd_ptr_q;
    logic [5:0] count_q;
    logic [5:0] rec_cnt_q;
    logic [4:0] run_len_q;
    logic       drop_q;
    logic       trunc_q;
    state_t     state_q, state_d;
    logic [7:0] char_q, char_d;
    logic       isstr_q, isstr_d;
    logic       ispat_q, ispat_d;
    logic       res_valid_q, res_valid_d;
    logic       res_match_q, res_match_d;
    logic [4:0] res_index_q, res_index_d;

    logic   accept, push, pop, trunc_now, rec_inc, rec_dec;
    entry_t push_entry, head;

    // DROP mode swallows the tail of an oversized record, so it must never back-pressure.
    assign in_ready   = drop_q || (count_q != 6'd32);
    assign accept     = in_valid && in_ready;
    assign push       = accept && !drop_q;
    assign trunc_now  = push && !in_last && (run_len_q == 5'd31);
    assign push_entry = '{typ: in_type, last: in_last || trunc_now, data: in_data};
    assign head       = mem[rd_ptr_q];
    assign rec_inc    = push && push_entry.last;
    assign rec_dec    = pop && head.last;

`ifdef SME_FEEDER_TIMEOUT_EN
    logic [11:0] wait_cnt_q;

    always_ff @(posedge clk) begin
        if (reset || state_q != WAIT) wait_cnt_q <= '0;
        else                          wait_cnt_q <= wait_cnt_q + 12'd1;
    end
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        char_d      = char_q;
        isstr_d     = 1'b0;
        ispat_d     = 1'b0;
        res_valid_d = 1'b0;
        res_match_d = res_match_q;
        res_index_d = res_index_q;
        unique case (state_q)
            IDLE: begin
                // Only start once a whole record is buffered, so the strobe never has holes.
                if (rec_cnt_q != 6'd0) state_d = head.typ ? PAT : STR;
            end
            STR, PAT: begin
                if (count_q != 6'd0) begin
                    pop     = 1'b1;
                    char_d  = head.data;
                    isstr_d = (state_q == STR);
                    ispat_d = (state_q == PAT);
                    if (head.last) state_d = (state_q == STR) ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (sme_valid) begin
                    res_valid_d = 1'b1;
                    res_match_d = sme_match;
                    res_index_d = sme_index;
                    state_d     = IDLE;
                end
`ifdef SME_FEEDER_TIMEOUT_EN
                else if (wait_cnt_q == 12'hFFF) begin
                    res_valid_d = 1'b1;
                    res_match_d = 1'b0;
                    res_index_d = 5'd0;
                    state_d     = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the storage array has no reset; pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= push_entry;
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rec_cnt_q   <= '0;
            run_len_q   <= '0;
            drop_q      <= 1'b0;
            trunc_q     <= 1'b0;
            state_q     <= IDLE;
            char_q      <= 8'h00;
            isstr_q     <= 1'b0;
            ispat_q     <= 1'b0;
            res_valid_q <= 1'b0;
            res_match_q <= 1'b0;
            res_index_q <= 5'd0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 5'd1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 5'd1;
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 6'd1;
                2'b01:   count_q <= count_q - 6'd1;
                default: ;
            endcase
            unique case ({rec_inc, rec_dec})
                2'b10:   rec_cnt_q <= rec_cnt_q + 6'd1;
                2'b01:   rec_cnt_q <= rec_cnt_q - 6'd1;
                default: ;
            endcase
            if (push) run_len_q <= push_entry.last ? 5'd0 : run_len_q + 5'd1;
            if (trunc_now)                           drop_q <= 1'b1;
            else if (drop_q && accept && in_last)    drop_q <= 1'b0;
            trunc_q     <= trunc_q | trunc_now;
            state_q     <= state_d;
            char_q      <= char_d;
            isstr_q     <= isstr_d;
            ispat_q     <= ispat_d;
            res_valid_q <= res_valid_d;
            res_match_q <= res_match_d;
            res_index_q <= res_index_d;
        end
    end

    assign chardata  = char_q;
    assign isstring  = isstr_q;
    assign ispattern = ispat_q;
    assign res_valid = res_valid_q;
    assign res_match = res_match_q;
    assign res_index = res_index_q;
    assign trunc_err = trunc_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sme_feeder.sv
// tb_sme_feeder: record-level model of sme_feeder; a negedge monitor compares each strobe burst
// against the expected record queue and answers pattern records with an SME result.
module tb_sme_feeder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0, in_type = 1'b0, in_last = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       sme_valid = 1'b0, sme_match = 1'b0;
    logic [4:0] sme_index = 5'd0;
    logic       in_ready, isstring, ispattern, res_valid, res_match, trunc_err, busy;
    logic [7:0] chardata;
    logic [4:0] res_index;

    always #5 clk = ~clk;

    sme_feeder dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_type(in_type), .in_last(in_last), .chardata(chardata), .isstring(isstring),
        .ispattern(ispattern), .sme_valid(sme_valid), .sme_match(sme_match), .sme_index(sme_index),
        .res_valid(res_valid), .res_match(res_match), .res_index(res_index),
        .trunc_err(trunc_err), .busy(busy)
    );

    int checks = 0;
    int failures = 0;

    // Expected output records: type, emitted length, and the emitted bytes back to back.
    bit           exp_type[$];
    int           exp_len[$];
    byte unsigned exp_data[$];
    bit           model_trunc = 1'b0;
    byte unsigned rec_q[$];

    // Monitor / responder state.
    bit           mon_active = 1'b0, cur_type = 1'b0;
    byte unsigned cur_q[$];
    int           strobe_cycles = 0, res_pulses = 0;
    int           resp_mode = 1;            // 0 never answer, 1 random answer, 2 fixed answer
    bit           fix_m = 1'b0;
    logic [4:0]   fix_i = 5'd0;
    bit           resp_pending = 1'b0, res_expect = 1'b0, allow_res = 1'b0;
    int           resp_delay = 0;
    bit           resp_m = 1'b0;
    logic [4:0]   resp_i = 5'd0;
    int           stray_req_cnt = 0, stray_done_cnt = 0;

    typedef struct {
        bit           typ;
        int           len;
        byte unsigned first;
        int           exp_emit;
        bit           exp_trunc;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic compare_burst();
        bit           et;
        int           el;
        byte unsigned b;
        if (exp_type.size() == 0) begin
            check("unexpected_burst_len", cur_q.size(), 0);
        end else begin
            et = exp_type.pop_front();
            el = exp_len.pop_front();
            check("burst_type", cur_type, et);
            check("burst_len", cur_q.size(), el);
            for (int i = 0; i < el; i++) begin
                b = exp_data.pop_front();
                if (i < cur_q.size()) check("burst_char", cur_q[i], b);
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            mon_active   = 1'b0;
            cur_q.delete();
            resp_pending = 1'b0;
            res_expect   = 1'b0;
            sme_valid    = 1'b0;
        end else begin
            if (res_expect) begin
                if (res_valid) res_pulses++;
                check("res_valid", res_valid, 1);
                check("res_match", res_match, resp_m);
                check("res_index", res_index, resp_i);
                check("busy_after_res", busy, 0);
                res_expect = 1'b0;
            end else begin
                if (res_valid) res_pulses++;
                if (!allow_res) check("no_spurious_res", res_valid, 0);
            end
            sme_valid = 1'b0;
            if (stray_req_cnt != stray_done_cnt) begin
                sme_valid = 1'b1;
                sme_match = 1'b1;
                sme_index = 5'd7;
                stray_done_cnt++;
            end else if (resp_pending) begin
                if (resp_delay == 0) begin
                    sme_valid    = 1'b1;
                    sme_match    = resp_m;
                    sme_index    = resp_i;
                    res_expect   = 1'b1;
                    resp_pending = 1'b0;
                end else begin
                    resp_delay--;
                end
            end
            check("strobe_exclusive", isstring & ispattern, 0);
            if (isstring || ispattern) begin
                strobe_cycles++;
                if (!mon_active) begin
                    mon_active = 1'b1;
                    cur_type   = ispattern;
                    cur_q.delete();
                end else begin
                    check("burst_gap", ispattern, cur_type);
                end
                cur_q.push_back(chardata);
            end else if (mon_active) begin
                mon_active = 1'b0;
                compare_burst();
                check("chardata_hold", chardata, cur_q[$]);
                if (cur_type && resp_mode != 0) begin
                    resp_pending = 1'b1;
                    resp_delay   = (resp_mode == 1) ? int'($urandom_range(0, 3)) : 5;
                    resp_m       = (resp_mode == 1) ? 1'($urandom_range(0, 1)) : fix_m;
                    resp_i       = (resp_mode == 1) ? 5'($urandom_range(0, 31)) : fix_i;
                end
            end
        end
    end

    task automatic send_byte(input bit t, input byte unsigned d, input bit l);
        int n = 0;
        in_valid = 1'b1;
        in_type  = t;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < 5000) begin
            tick();
            n++;
        end
        check("send_accepted", int'(n < 5000), 1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_rec(input bit t, input bit with_last, input int max_gap);
        for (int i = 0; i < rec_q.size(); i++) begin
            repeat ($urandom_range(0, max_gap)) tick();
            send_byte(t, rec_q[i], with_last && (i == rec_q.size() - 1));
        end
    endtask

    task automatic push_exp(input bit t, input int n);
        exp_type.push_back(t);
        exp_len.push_back(n);
        for (int i = 0; i < n; i++) exp_data.push_back(rec_q[i]);
    endtask

    task automatic set_rec_str(input string s);
        rec_q.delete();
        for (int i = 0; i < s.len(); i++) rec_q.push_back(s[i]);
    endtask

    task automatic set_rec_seq(input byte unsigned first, input int len);
        rec_q.delete();
        for (int i = 0; i < len; i++) rec_q.push_back(8'(first + i));
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_type.size() != 0 || busy || resp_pending || res_expect) && n < 4000) begin
            tick();
            n++;
        end
        check("drain_done", int'(n < 4000), 1);
        tick();
    endtask

    task automatic wait_exp_empty();
        int n = 0;
        while (exp_type.size() != 0 && n < 2000) begin
            tick();
            n++;
        end
        check("exp_consumed", int'(n < 2000), 1);
        repeat (3) tick();
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_last  = 1'b0;
        reset    = 1'b1;
        exp_type.delete();
        exp_len.delete();
        exp_data.delete();
        model_trunc = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic check_reset_values();
        check("rst_in_ready", in_ready, 1);
        check("rst_chardata", chardata, 0);
        check("rst_isstring", isstring, 0);
        check("rst_ispattern", ispattern, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_match", res_match, 0);
        check("rst_res_index", res_index, 0);
        check("rst_trunc_err", trunc_err, 0);
        check("rst_busy", busy, 0);
    endtask

    initial begin
        int s0, r0, n, len;
        bit t;

        vecs[0] = '{typ: 1'b0, len: 4,  first: 8'h61, exp_emit: 4,  exp_trunc: 1'b0};
        vecs[1] = '{typ: 1'b1, len: 2,  first: 8'h62, exp_emit: 2,  exp_trunc: 1'b0};
        vecs[2] = '{typ: 1'b0, len: 32, first: 8'h41, exp_emit: 32, exp_trunc: 1'b0};
        vecs[3] = '{typ: 1'b1, len: 1,  first: 8'h7a, exp_emit: 1,  exp_trunc: 1'b0};
        vecs[4] = '{typ: 1'b0, len: 33, first: 8'h30, exp_emit: 32, exp_trunc: 1'b1};
        vecs[5] = '{typ: 1'b1, len: 5,  first: 8'h6b, exp_emit: 5,  exp_trunc: 1'b1};

        tick();
        tick();
        reset = 1'b0;
        check_reset_values();

        // sme_valid while IDLE must be ignored.
        r0 = res_pulses;
        stray_req_cnt++;
        repeat (4) tick();
        check("stray_sme_ignored", res_pulses - r0, 0);
        check("stray_busy", busy, 0);

        // "abcd" string then "bc" pattern, answered with match=1 index=1.
        resp_mode = 2;
        fix_m = 1'b1;
        fix_i = 5'd1;
        r0 = res_pulses;
        set_rec_str("abcd"); push_exp(1'b0, 4); send_rec(1'b0, 1'b1, 0);
        set_rec_str("bc");   push_exp(1'b1, 2); send_rec(1'b1, 1'b1, 0);
        wait_drain();
        check("basic_res_pulses", res_pulses - r0, 1);
        check("basic_res_match_held", res_match, 1);
        check("basic_res_index_held", res_index, 1);
        resp_mode = 1;

        // Partial record must not be emitted until its last byte arrives.
        s0 = strobe_cycles;
        set_rec_str("ab"); send_rec(1'b0, 1'b0, 0);
        repeat (10) tick();
        check("partial_no_strobe", strobe_cycles - s0, 0);
        set_rec_str("abc"); push_exp(1'b0, 3);
        send_byte(1'b0, 8'h63, 1'b1);
        wait_drain();

        // 40-byte string truncates to 32, tail dropped, following pattern intact.
        set_rec_seq(8'h40, 40); push_exp(1'b0, 32); send_rec(1'b0, 1'b1, 0);
        set_rec_str("xy");      push_exp(1'b1, 2);  send_rec(1'b1, 1'b1, 0);
        wait_drain();
        check("trunc_err_set", trunc_err, 1);

        // Table of records with fixed expected emit length and sticky truncation flag.
        do_reset();
        for (int v = 0; v < 6; v++) begin
            set_rec_seq(vecs[v].first, vecs[v].len);
            push_exp(vecs[v].typ, vecs[v].exp_emit);
            send_rec(vecs[v].typ, 1'b1, 1);
            wait_drain();
            check("vec_trunc_err", trunc_err, vecs[v].exp_trunc);
        end

        // Random records against the record-level model.
        do_reset();
        for (int r = 0; r < 30; r++) begin
            len = $urandom_range(1, 40);
            t   = 1'($urandom_range(0, 1));
            rec_q.delete();
            for (int i = 0; i < len; i++) rec_q.push_back(8'($urandom));
            push_exp(t, (len > 32) ? 32 : len);
            if (len > 32) model_trunc = 1'b1;
            send_rec(t, 1'b1, 2);
        end
        wait_drain();
        check("rand_trunc_err", trunc_err, model_trunc);

        // Pattern left unanswered in WAIT.
        do_reset();
        resp_mode = 0;
        r0 = res_pulses;
        set_rec_str("pq"); push_exp(1'b1, 2); send_rec(1'b1, 1'b1, 0);
        wait_exp_empty();
`ifdef SME_FEEDER_TIMEOUT_EN
        allow_res = 1'b1;
        n = 0;
        while (!res_valid && n < 5000) begin
            tick();
            n++;
        end
        check("timeout_window", int'(n >= 4090 && n <= 4100), 1);
        check("timeout_res_match", res_match, 0);
        check("timeout_res_index", res_index, 0);
        tick();
        allow_res = 1'b0;
        r0 = res_pulses;
        set_rec_str("pq"); push_exp(1'b1, 2); send_rec(1'b1, 1'b1, 0);
        wait_exp_empty();
`else
        for (int i = 0; i < 10000; i++) tick();
        check("wait_no_res_10000", res_pulses - r0, 0);
        check("wait_still_busy", busy, 1);
`endif

        // Fill the FIFO behind the stalled pattern.
        for (int r = 0; r < 4; r++) begin
            set_rec_seq(8'(8'h10 * r), 8);
            send_rec(1'b0, 1'b1, 0);
        end
        check("full_in_ready_low", in_ready, 0);
        in_valid = 1'b1;
        in_data  = 8'hff;
        in_last  = 1'b1;
        repeat (5) tick();
        check("full_in_ready_held", in_ready, 0);

        // Reset in WAIT with a full FIFO: everything buffered is discarded.
        s0 = strobe_cycles;
        r0 = res_pulses;
        do_reset();
        check_reset_values();
        repeat (40) tick();
        check("wait_reset_no_strobe", strobe_cycles - s0, 0);
        check("wait_reset_no_res", res_pulses - r0, 0);

        // Reset in the middle of a pattern burst.
        resp_mode = 1;
        set_rec_seq(8'h50, 20); push_exp(1'b1, 20); send_rec(1'b1, 1'b1, 0);
        n = 0;
        while (!ispattern && n < 100) begin
            tick();
            n++;
        end
        check("pat_started", ispattern, 1);
        repeat (3) tick();
        do_reset();
        check_reset_values();
        s0 = strobe_cycles;
        r0 = res_pulses;
        repeat (30) tick();
        check("pat_reset_no_strobe", strobe_cycles - s0, 0);
        check("pat_reset_no_res", res_pulses - r0, 0);
        check("pat_reset_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sme_feeder.md
SME_FEEDER -- requirements
Module: sme_feeder

Interface
REQ-001 The block SHALL use reset reset, synchronous, active-high; clock clk.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  clock
- reset  in  1  sync active-high reset
- in_valid  in  1  upstream byte valid
- in_ready  out  1  block accepts byte this cycle
- in_data  in  8  ASCII byte
- in_type  in  1  0 = string record, 1 = pattern record; sampled per byte
- in_last  in  1  final byte of record
- chardata  out  8  byte to SME
- isstring  out  1  string char strobe to SME
- ispattern  out  1  pattern char strobe to SME
- sme_valid  in  1  SME result valid
- sme_match  in  1  SME match flag
- sme_index  in  5  SME match index
- res_valid  out  1  one-cycle result pulse
- res_match  out  1  captured match
- res_index  out  5  captured index
- trunc_err  out  1  sticky: record exceeded 32 bytes
- busy  out  1  state != IDLE

Function
REQ-003 A byte SHALL transfer when in_valid && in_ready on posedge clk.
REQ-004 Accepted bytes SHALL be written as {type,last,data} into a 32-entry FIFO; in_ready = !full, or 1 while in DROP mode.
REQ-005 A complete-record counter (0..32) SHALL increment on write of an entry with last=1, decrement on pop of such an entry; simultaneous increment and decrement SHALL leave it unchanged.
REQ-006 On write of the 32nd consecutive byte of a record without in_last, the entry SHALL be stored with last=1, trunc_err set, and DROP mode entered: subsequent bytes accepted and discarded up to and including the next in_last byte.
REQ-007 FSM states SHALL be IDLE, STR, PAT, WAIT.
REQ-008 IDLE -> STR or PAT (per head type) SHALL occur only when record counter > 0, so a record is never emitted with gaps.
REQ-009 In STR/PAT, one entry SHALL pop per cycle; chardata, isstring or ispattern SHALL be registered and valid the cycle after the pop.
REQ-010 On pop of the last entry: STR -> IDLE; PAT -> WAIT; isstring/ispattern SHALL be 0 the cycle after the final character.
REQ-011 IDLE SHALL last at least one cycle between records (strobe always drops for >= 1 cycle).
REQ-012 In WAIT, on sme_valid=1, res_match/res_index SHALL capture sme_match/sme_index, res_valid SHALL pulse for exactly one cycle, FSM -> IDLE.
REQ-013 sme_valid outside WAIT SHALL be ignored.
REQ-014 chardata SHALL hold its last value when both strobes are 0.
REQ-015 FIFO writes SHALL continue during STR/PAT/WAIT; simultaneous push and pop at full SHALL be permitted only when in_ready was asserted (in_ready not dependent on pop).

Reset
REQ-016 On reset: FIFO pointers, count and record counter SHALL clear; FSM -> IDLE; DROP cleared.
REQ-017 Reset values: in_ready 1, chardata 8'h00, isstring 0, ispattern 0, res_valid 0, res_match 0, res_index 0, trunc_err 0, busy 0.
REQ-018 Reset mid-record or in WAIT SHALL abort with no res_valid pulse and all buffered bytes discarded.

Configuration
REQ-019 Macro SME_FEEDER_TIMEOUT_EN: when defined, a 12-bit counter SHALL run in WAIT; after 4095 cycles without sme_valid, res_valid SHALL pulse with res_match=0, res_index=0, FSM -> IDLE; when undefined, WAIT SHALL persist indefinitely.

Verification
REQ-020 String "abcd" (type 0, last on 'd') then pattern "bc" -> isstring high 4 cycles chars a,b,c,d; >=1 idle cycle; ispattern high 2 cycles b,c; WAIT until sme_valid.
REQ-021 In WAIT drive sme_valid=1, sme_match=1, sme_index=5'd1 -> res_valid single pulse, res_match=1, res_index=1, busy 0 next cycle.
REQ-022 Partial string "ab" without last, 10 idle cycles -> no strobes; then "c" with last -> isstring 3 contiguous cycles a,b,c.
REQ-023 40-byte string -> 32 chars emitted, trunc_err=1, bytes 33-40 dropped, following pattern emitted normally.
REQ-024 Hold in_valid with sme_valid never asserted until FIFO fills -> in_ready 0 at count 32, no overflow; reset mid-PAT -> all outputs at reset values, no res_valid.
REQ-025 With SME_FEEDER_TIMEOUT_EN, pattern sent and no sme_valid -> res_valid at WAIT cycle 4096 with res_match=0; without macro -> no pulse after 10000 cycles.
